mem_ctrl32: RTL and testbench
=============================

MEM_CTRL32 -- requirements
Module: mem_ctrl32

Interface
REQ-001 Parameter WADDR_W, default 2: 32-bit word address width (4 words).
REQ-002 Parameter HALF_W, default 16: memory data width per access.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  controller can accept a request.
REQ-007 req_rw  input  1  0 = write, 1 = read (matches memory R_W polarity).
REQ-008 req_addr  input  WADDR_W  32-bit word address.
REQ-009 req_wdata  input  32  write data.
REQ-010 rsp_valid  output  1  one-cycle completion pulse (reads and writes).
REQ-011 rsp_rdata  output  32  read data.
REQ-012 mem_enable  output  1  drives memory enable.
REQ-013 mem_rw  output  1  drives memory R_W.
REQ-014 mem_addr  output  3  drives memory halfword address.
REQ-015 mem_din  output  HALF_W  drives memory D_In.
REQ-016 mem_dout  input  HALF_W  memory D_Out; valid in the same cycle as an enabled read address.

Function
REQ-017 FSM states IDLE, LO, HI, RESP; transitions IDLE->LO on accept, LO->HI, HI->RESP, RESP->IDLE, all unconditional except IDLE.
REQ-018 req_ready = 1 only in IDLE; accept = req_valid & req_ready at a rising edge.
REQ-019 On accept, req_rw, req_addr, req_wdata are latched; later input changes have no effect on the transaction.
REQ-020 req_valid outside IDLE is ignored; no request is queued.
REQ-021 LO: mem_enable=1, mem_rw=latched rw, mem_addr={addr,1'b0}, mem_din=wdata[15:0].
REQ-022 HI: mem_enable=1, mem_rw=latched rw, mem_addr={addr,1'b1}, mem_din=wdata[31:16].
REQ-023 IDLE and RESP: mem_enable=0, mem_rw=1, mem_addr=0, mem_din=0.
REQ-024 Read: mem_dout captured into rsp_rdata[15:0] at end of LO, rsp_rdata[31:16] at end of HI.
REQ-025 rsp_valid = 1 only in RESP; latency accept-edge to rsp_valid = 3 cycles; throughput one transaction per 4 cycles.
REQ-026 Writes do not modify rsp_rdata; rsp_rdata holds the last completed read value.
REQ-027 All outputs derived from registers only; no combinational path from req_* inputs to mem_* or rsp_* outputs.
REQ-028 Address wrap: req_addr = 3 maps to halfwords 6 and 7; no out-of-range access possible.

Reset
REQ-029 Reset asserted: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, mem_enable=0, mem_rw=1, mem_addr=0, mem_din=0, latched request=0.
REQ-030 Reset mid-transaction aborts it: no rsp_valid; a completed low-half write remains in memory.
REQ-031 First accept possible at the first rising edge after reset deasserts.

Structure
REQ-032 Shared package holds FSM state encoding, RW_WRITE=0/RW_READ=1 constants and HALF_W default.
REQ-033 Single module; no sub-modules; the 8x16 memory is instantiated only in the bench and the top level.

Verification
REQ-034 Write addr=1 data=32'hDEADBEEF -> memory halfword 2=16'hBEEF, halfword 3=16'hDEAD; rsp_valid 3 cycles after accept.
REQ-035 Write then read addr=1 -> rsp_rdata=32'hDEADBEEF with rsp_valid pulse; mem_enable low in IDLE/RESP.
REQ-036 Write all four words 32'h11112222..32'h77778888, dump memory -> halfwords 0..7 in low/high order as given.
REQ-037 req_valid held high with changing req_addr during LO/HI -> ignored; exactly one transaction per 4 cycles, latched address used.
REQ-038 Reset asserted during HI of write addr=2 data=32'hCAFEF00D -> halfword 4=16'hF00D, halfword 5 unchanged, no rsp_valid, outputs at reset values immediately.
REQ-039 Read after write of addr=3 -> rsp_rdata updates; subsequent write leaves rsp_rdata unchanged.

Source files
------------

// File: rtl/mem_ctrl32_pkg.sv
// Shared definitions for the 32-bit-over-16-bit memory controller.
//   state_t     : FSM state encoding (IDLE, LO, HI, RESP)
//   RW_WRITE/RW_READ : R_W polarity shared by request port and memory
//   HALF_W_DEF  : default memory data width per access
package mem_ctrl32_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic RW_WRITE   = 1'b0;
  localparam logic RW_READ    = 1'b1;
  localparam int   HALF_W_DEF = 16;

endpackage

// File: rtl/mem_ctrl32.sv
// mem_ctrl32: splits each 32-bit word request into two 16-bit memory
// accesses (low half, then high half) and returns a one-cycle completion.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   req_valid/ready  : request handshake (ready only in IDLE)
//   req_rw/addr/wdata: 0=write 1=read, word address, write data
//   rsp_valid/rdata  : completion pulse, last completed read data
//   mem_enable/rw/addr/din : memory drive; mem_dout : memory read data
// Assumes 2*HALF_W == 32.
module mem_ctrl32
  import mem_ctrl32_pkg::*;
#(
  parameter int WADDR_W = 2,
  parameter int HALF_W  = HALF_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_rw,
  input  logic [WADDR_W-1:0] req_addr,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic               mem_enable,
  output logic               mem_rw,
  output logic [WADDR_W:0]   mem_addr,
  output logic [HALF_W-1:0]  mem_din,
  input  logic [HALF_W-1:0]  mem_dout
);

  state_t             state, state_nxt;
  logic               rw_q;
  logic [WADDR_W-1:0] addr_q;
  logic [31:0]        wdata_q;
  logic               accept;

  assign accept = req_valid && (state == S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Request is captured once; inputs are ignored for the rest of the transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw_q    <= RW_WRITE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      rw_q    <= req_rw;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Memory read data is combinational off the address driven this cycle,
  // so each half is sampled at the end of the state that presented it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_rdata <= '0;
    end else if (rw_q == RW_READ) begin
      if (state == S_LO) rsp_rdata[HALF_W-1:0]        <= mem_dout;
      if (state == S_HI) rsp_rdata[2*HALF_W-1:HALF_W] <= mem_dout;
    end
  end

  // Outputs decode only from state and latched request registers.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    mem_enable = 1'b0;
    mem_rw     = RW_READ;
    mem_addr   = '0;
    mem_din    = '0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = S_LO;
      end
      S_LO: begin
        mem_enable = 1'b1;
        mem_rw     = rw_q;
        mem_addr   = {addr_q, 1'b0};
        mem_din    = wdata_q[HALF_W-1:0];
        state_nxt  = S_HI;
      end
      S_HI: begin
        mem_enable = 1'b1;
        mem_rw     = rw_q;
        mem_addr   = {addr_q, 1'b1};
        mem_din    = wdata_q[2*HALF_W-1:HALF_W];
        state_nxt  = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl32.sv
// Bench for mem_ctrl32: 8x16 memory model, reference word memory, and a
// scoreboard of expected completions (cycle + read data) popped by a monitor.
module tb_mem_ctrl32;
  import mem_ctrl32_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_rw;
  logic [1:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        mem_enable, mem_rw;
  logic [2:0]  mem_addr;
  logic [15:0] mem_din, mem_dout;

  mem_ctrl32 #(.WADDR_W(2), .HALF_W(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // 8x16 memory: synchronous write, asynchronous read
  logic [15:0] mem [0:7];
  assign mem_dout = mem[mem_addr];
  always @(posedge clk)
    if (mem_enable && mem_rw == RW_WRITE) mem[mem_addr] <= mem_din;

  // Reference state, word-level view
  logic [15:0] ref_mem [0:7];
  logic [31:0] last_read;

  typedef struct { int cyc; logic [31:0] data; } exp_t;
  exp_t q[$];

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (rsp_valid) begin
        if (q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("rsp_latency", cyc, e.cyc);
          check("rsp_rdata", rsp_rdata, e.data);
        end
      end
      if (req_ready || rsp_valid)
        check("mem_idle_drive", {11'd0, mem_enable, mem_rw, mem_addr, mem_din},
              {11'd0, 1'b0, 1'b1, 3'd0, 16'd0});
    end
  end

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic issue(input logic rw, input logic [1:0] addr, input logic [31:0] wd, input bit hold);
    exp_t e;
    check("ready_at_issue", req_ready, 1'b1);
    req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wd;
    if (rw == RW_WRITE) begin
      ref_mem[addr*2]   = wd[15:0];
      ref_mem[addr*2+1] = wd[31:16];
    end else begin
      last_read = {ref_mem[addr*2+1], ref_mem[addr*2]};
    end
    e.cyc = cyc + 3;
    e.data = last_read;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    // Disturb inputs while busy; nothing must be accepted.
    repeat (3) begin
      req_valid = hold ? 1'b1 : 1'($urandom);
      req_rw    = 1'($urandom);
      req_addr  = 2'($urandom);
      req_wdata = $urandom;
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=%0d expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  logic [31:0] wtbl [4];
  logic [15:0] htbl [8];
  logic [15:0] hw5_saved;
  logic [31:0] d;

  initial begin
    wtbl = '{32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888};
    htbl = '{16'h2222, 16'h1111, 16'h4444, 16'h3333,
             16'h6666, 16'h5555, 16'h8888, 16'h7777};
    for (int i = 0; i < 8; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    last_read = '0;
    reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0;
    #1;
    check("rst_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_mem_drive", {mem_enable, mem_rw, mem_addr, mem_din}, {1'b0, 1'b1, 3'd0, 16'd0});
    @(negedge clk);
    reset = 1'b0;

    // Accept on first edge after reset release
    issue(RW_WRITE, 2'd1, 32'hDEADBEEF, 1'b1);
    check("wr_hw2", mem[2], 16'hBEEF);
    check("wr_hw3", mem[3], 16'hDEAD);
    issue(RW_READ, 2'd1, 32'h0, 1'b1);

    for (int i = 0; i < 4; i++) issue(RW_WRITE, 2'(i), wtbl[i], 1'b0);
    for (int i = 0; i < 8; i++) check("dump_all", mem[i], htbl[i]);

    issue(RW_READ, 2'd3, 32'h0, 1'b0);
    check("rd_addr3_data", rsp_rdata, 32'h77778888);
    issue(RW_WRITE, 2'd3, 32'h0BADF00D, 1'b1);
    check("rdata_after_write", rsp_rdata, 32'h77778888);

    for (int n = 0; n < 40; n++) begin
      issue(1'($urandom), 2'($urandom), $urandom, 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset during HI of a write: low half lands, high half does not
    hw5_saved = ref_mem[5];
    req_valid = 1'b1; req_rw = RW_WRITE; req_addr = 2'd2; req_wdata = 32'hCAFEF00D;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_addr = 2'd0;
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_ready", req_ready, 1'b1);
    check("abort_rsp_valid", rsp_valid, 1'b0);
    check("abort_rdata", rsp_rdata, 32'd0);
    check("abort_mem_drive", {mem_enable, mem_rw, mem_addr, mem_din}, {1'b0, 1'b1, 3'd0, 16'd0});
    @(negedge clk);
    reset = 1'b0;
    ref_mem[4] = 16'hF00D;
    last_read = '0;
    check("abort_hw4", mem[4], 16'hF00D);
    check("abort_hw5", mem[5], hw5_saved);
    repeat (3) @(negedge clk);

    d = {hw5_saved, 16'hF00D};
    issue(RW_READ, 2'd2, 32'h0, 1'b0);
    check("post_reset_read", rsp_rdata, d);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", q.size(), 32'd0);
    for (int i = 0; i < 8; i++) check("final_dump", mem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
